// File: rtl/wagu_pkg.sv
// Shared definitions for the FC weight address generator:
// FSM state encoding and the mode code that selects FC operation.
package wagu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_FEAT = 4'd1,
    ST_READ      = 4'd2,
    ST_GROUP_END = 4'd3,
    ST_DONE      = 4'd4
  } wagu_state_e;

  localparam logic [3:0] MODE_FC = 4'd2;

endpackage

// File: rtl/wagu_fc.sv
// FC weight address generator: walks the weight buffer linearly from a base
// address, one read per cycle, handshaking with IAGU between feature groups.
module wagu_fc
  import wagu_pkg::*;
#(
  parameter int unsigned GROUP_LEN = 16,
  parameter logic [3:0]  MODE_FC   = wagu_pkg::MODE_FC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_calculate,
  input  logic        feature_load_end,
  input  logic [3:0]  mode,
  input  logic [11:0] addr_start_w,
  input  logic [7:0]  in_piece,
  input  logic [7:0]  out_piece,
  output logic [11:0] o_w_addr,
  output logic        o_rd_en,
  output logic        o_group_end,
  output logic        o_fc_out,
  output logic [3:0]  o_r_WorkState,
  output logic [3:0]  o_r_WorkState_next,
  output logic [7:0]  o_piece,
  output logic [5:0]  o_group_cnt
);

  localparam logic [5:0] LAST_WORD = 6'(GROUP_LEN - 1);

  wagu_state_e state_q, state_d;
  logic [11:0] addr_cnt_q, addr_cnt_d;
  logic [7:0]  in_cnt_q, in_cnt_d;
  logic [7:0]  in_piece_q, in_piece_d;
  logic [7:0]  out_piece_q, out_piece_d;
  logic [7:0]  piece_q, piece_d;
  logic [5:0]  group_cnt_q, group_cnt_d;

  logic start_ok;
  logic word_last;
  logic piece_last;
  logic group_last;

  // A start is only honoured for FC layers with a non-empty shape.
  assign start_ok   = start_calculate && (mode == MODE_FC) &&
                      (in_piece != 8'd0) && (out_piece != 8'd0);
  assign word_last  = (group_cnt_q == LAST_WORD);
  assign piece_last = (piece_q == out_piece_q - 8'd1);
  assign group_last = (in_cnt_q == in_piece_q - 8'd1);

  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    in_cnt_d    = in_cnt_q;
    in_piece_d  = in_piece_q;
    out_piece_d = out_piece_q;
    piece_d     = piece_q;
    group_cnt_d = group_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          addr_cnt_d  = addr_start_w;
          in_piece_d  = in_piece;
          out_piece_d = out_piece;
          in_cnt_d    = 8'd0;
          piece_d     = 8'd0;
          group_cnt_d = 6'd0;
          state_d     = ST_WAIT_FEAT;
        end
      end
      ST_WAIT_FEAT: begin
        if (feature_load_end) state_d = ST_READ;
      end
      ST_READ: begin
        // Address never resets between pieces or groups; wraps at 4096.
        addr_cnt_d = addr_cnt_q + 12'd1;
        if (word_last) begin
          group_cnt_d = 6'd0;
          if (piece_last) begin
            piece_d = 8'd0;
            state_d = ST_GROUP_END;
          end else begin
            piece_d = piece_q + 8'd1;
          end
        end else begin
          group_cnt_d = group_cnt_q + 6'd1;
        end
      end
      ST_GROUP_END: begin
        in_cnt_d = in_cnt_q + 8'd1;
        state_d  = group_last ? ST_DONE : ST_WAIT_FEAT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_cnt_q  <= 12'd0;
      in_cnt_q    <= 8'd0;
      in_piece_q  <= 8'd0;
      out_piece_q <= 8'd0;
      piece_q     <= 8'd0;
      group_cnt_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      in_cnt_q    <= in_cnt_d;
      in_piece_q  <= in_piece_d;
      out_piece_q <= out_piece_d;
      piece_q     <= piece_d;
      group_cnt_q <= group_cnt_d;
    end
  end

  assign o_rd_en            = (state_q == ST_READ);
  assign o_w_addr           = o_rd_en ? addr_cnt_q : 12'd0;
  assign o_group_end        = (state_q == ST_GROUP_END);
  assign o_fc_out           = (state_q == ST_DONE);
  assign o_r_WorkState      = state_q;
  assign o_r_WorkState_next = rst ? ST_IDLE : state_d;
  assign o_piece            = piece_q;
  assign o_group_cnt        = group_cnt_q;

endmodule

// File: tb/tb_wagu_fc.sv
// Scoreboard bench for wagu_fc: stimulus queues expected events, a negedge
// monitor pops and compares every read / group-end / fc-out the DUT presents.
module tb_wagu_fc;
  import wagu_pkg::*;

  localparam int GL = 16;

  typedef enum int {EV_READ = 0, EV_GEND = 1, EV_FCOUT = 2} ev_e;
  typedef struct {
    ev_e         kind;
    logic [11:0] addr;
    logic [7:0]  piece;
    logic [5:0]  gcnt;
    bit          first;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  prev_rd = 0;

  logic        clk = 0;
  logic        rst = 1;
  logic        start_calculate = 0;
  logic        feature_load_end = 0;
  logic [3:0]  mode = 4'd0;
  logic [11:0] addr_start_w = 12'd0;
  logic [7:0]  in_piece = 8'd0;
  logic [7:0]  out_piece = 8'd0;
  logic [11:0] o_w_addr;
  logic        o_rd_en, o_group_end, o_fc_out;
  logic [3:0]  o_r_WorkState, o_r_WorkState_next;
  logic [7:0]  o_piece;
  logic [5:0]  o_group_cnt;

  wagu_fc #(.GROUP_LEN(GL), .MODE_FC(4'd2)) dut (
    .clk(clk), .rst(rst), .start_calculate(start_calculate),
    .feature_load_end(feature_load_end), .mode(mode),
    .addr_start_w(addr_start_w), .in_piece(in_piece), .out_piece(out_piece),
    .o_w_addr(o_w_addr), .o_rd_en(o_rd_en), .o_group_end(o_group_end),
    .o_fc_out(o_fc_out), .o_r_WorkState(o_r_WorkState),
    .o_r_WorkState_next(o_r_WorkState_next), .o_piece(o_piece),
    .o_group_cnt(o_group_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input ev_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d with nothing expected (t=%0t)", k, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      if (k == EV_READ && e.kind == EV_READ) begin
        chk("read_addr", o_w_addr, e.addr);
        chk("read_piece", o_piece, e.piece);
        chk("read_gcnt", o_group_cnt, e.gcnt);
        if (!e.first) chk("read_contig", prev_rd, 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (o_rd_en === 1'b1)     pop_check(EV_READ);
    if (o_group_end === 1'b1) pop_check(EV_GEND);
    if (o_fc_out === 1'b1)    pop_check(EV_FCOUT);
    prev_rd = (o_rd_en === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [11:0] a, input int p, input int w);
    ev_t e;
    e.kind = EV_READ; e.addr = a; e.piece = 8'(p); e.gcnt = 6'(w);
    e.first = (p == 0 && w == 0);
    exp_q.push_back(e);
  endtask

  task automatic push_kind(input ev_e k);
    ev_t e;
    e.kind = k; e.addr = 12'd0; e.piece = 8'd0; e.gcnt = 6'd0; e.first = 1;
    exp_q.push_back(e);
  endtask

  task automatic push_layer(input logic [11:0] base, input int inp, input int outp);
    logic [11:0] a;
    a = base;
    for (int g = 0; g < inp; g++) begin
      for (int p = 0; p < outp; p++)
        for (int w = 0; w < GL; w++) begin
          push_read(a, p, w);
          a = a + 12'd1;
        end
      push_kind(EV_GEND);
    end
    push_kind(EV_FCOUT);
  endtask

  task automatic wait_state(input logic [3:0] target, input int budget, input string name);
    int n = 0;
    while (o_r_WorkState !== target && n < budget) begin
      tick();
      n++;
    end
    chk(name, o_r_WorkState, target);
  endtask

  task automatic run_layer(input logic [11:0] base, input int inp, input int outp,
                           input int gap, input bit spur);
    mode = 4'd2; addr_start_w = base;
    in_piece = 8'(inp); out_piece = 8'(outp);
    push_layer(base, inp, outp);
    start_calculate = 1;
    tick();
    start_calculate = 0;
    // Change the live inputs so any re-latch would show in the addresses.
    addr_start_w = 12'hABC; in_piece = 8'd7; out_piece = 8'd7;
    chk("wait_entry", o_r_WorkState, ST_WAIT_FEAT);
    for (int g = 0; g < inp; g++) begin
      wait_state(ST_WAIT_FEAT, 4 * GL * outp + 8, "reach_wait");
      for (int i = 0; i < gap; i++) begin
        if (spur && i == 0) start_calculate = 1;
        @(negedge clk);
        chk("wait_hold_rd", o_rd_en, 0);
        chk("wait_hold_state", o_r_WorkState, ST_WAIT_FEAT);
        tick();
        start_calculate = 0;
      end
      feature_load_end = 1;
      tick();
      feature_load_end = 0;
      if (spur) begin
        feature_load_end = 1; start_calculate = 1;
        tick(); tick();
        feature_load_end = 0; start_calculate = 0;
      end
    end
    wait_state(ST_IDLE, 4 * GL * outp + 8, "layer_idle");
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic reject(input logic [3:0] m, input int ip, input int op);
    mode = m; in_piece = 8'(ip); out_piece = 8'(op); addr_start_w = 12'h050;
    start_calculate = 1;
    tick();
    start_calculate = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reject_state", o_r_WorkState, ST_IDLE);
      chk("reject_rd", o_rd_en, 0);
      tick();
    end
  endtask

  initial begin
    int n;
    repeat (2) tick();
    chk("rst_state", o_r_WorkState, ST_IDLE);
    chk("rst_next_state", o_r_WorkState_next, ST_IDLE);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_addr", o_w_addr, 0);
    chk("rst_group_end", o_group_end, 0);
    chk("rst_fc_out", o_fc_out, 0);
    chk("rst_piece", o_piece, 0);
    chk("rst_gcnt", o_group_cnt, 0);
    rst = 0;
    tick();

    run_layer(12'h000, 1, 2, 2, 0);   // single group, two pieces
    run_layer(12'h100, 3, 1, 3, 0);   // multiple groups
    run_layer(12'hFF8, 1, 1, 0, 0);   // address wrap
    reject(4'd1, 1, 1);
    reject(4'd2, 0, 1);
    reject(4'd2, 1, 0);
    run_layer(12'h400, 1, 2, 2, 1);   // spurious fle / start

    // Reset during READ at word 5: six reads seen, then nothing.
    mode = 4'd2; addr_start_w = 12'h200; in_piece = 8'd1; out_piece = 8'd1;
    for (int w = 0; w < 6; w++) push_read(12'h200 + 12'(w), 0, w);
    start_calculate = 1; tick(); start_calculate = 0;
    feature_load_end = 1; tick(); feature_load_end = 0;
    n = 0;
    while (o_group_cnt !== 6'd5 && n < 40) begin tick(); n++; end
    chk("rst_point_gcnt", o_group_cnt, 5);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_next_state", o_r_WorkState_next, ST_IDLE);
    tick();
    chk("rst_mid_state", o_r_WorkState, ST_IDLE);
    chk("rst_mid_rd_en", o_rd_en, 0);
    chk("rst_mid_addr", o_w_addr, 0);
    chk("rst_mid_piece", o_piece, 0);
    chk("rst_mid_gcnt", o_group_cnt, 0);
    chk("rst_mid_gend", o_group_end, 0);
    chk("rst_mid_fc", o_fc_out, 0);
    rst = 0;
    repeat (4) tick();
    chk("rst_mid_idle_hold", o_r_WorkState, ST_IDLE);
    chk("rst_mid_queue", exp_q.size(), 0);
    run_layer(12'h300, 1, 1, 1, 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wagu_fc.md
# wagu_fc

Weight address generation unit for fully-connected (FC) layers. It runs after the schedule issues a start and walks the weight buffer linearly from a programmed base address. It emits one read per cycle for every output piece of the current input-feature group. Between groups it handshakes with the input address generator (IAGU), and when the layer completes it signals the NPE.

## Interface
- `GROUP_LEN`, default 16: weight words read per output piece per group, range 1..64.
- `MODE_FC`, default 4'd2: `mode` value that selects FC operation.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start_calculate` in 1: start pulse from the schedule.
- `feature_load_end` in 1: pulse from IAGU meaning the next feature group is loaded.
- `mode` in 4: layer mode from the decoder.
- `addr_start_w` in 12: weight base address.
- `in_piece` in 8: number of input groups.
- `out_piece` in 8: number of output pieces.
- `o_w_addr` out 12: weight buffer read address.
- `o_rd_en` out 1: weight buffer read enable.
- `o_group_end` out 1: one-cycle pulse to IAGU when a group's reads are finished.
- `o_fc_out` out 1: one-cycle pulse to the NPE when the layer is finished.
- `o_r_WorkState` out 4: current state register.
- `o_r_WorkState_next` out 4: combinational next state.
- `o_piece` out 8: current output-piece index.
- `o_group_cnt` out 6: word index within the current piece.

## Operation
- State encoding: IDLE=0, WAIT_FEAT=1, READ=2, GROUP_END=3, DONE=4. Other codes recover to IDLE.
- **IDLE**
  - Leaves IDLE only when `start_calculate` is high, `mode==MODE_FC`, and `in_piece` and `out_piece` are both nonzero.
  - On that start: latch `addr_start_w` into `addr_cnt`, latch `in_piece` and `out_piece`, clear `in_cnt`, `o_piece` and `o_group_cnt`, then go to WAIT_FEAT.
  - Any other start is ignored.
- **WAIT_FEAT**: go to READ on `feature_load_end`, otherwise hold.
- **READ**
  - `o_rd_en=1` and `o_w_addr=addr_cnt`.
  - Every cycle: `addr_cnt` increments and `o_group_cnt` increments.
  - When `o_group_cnt==GROUP_LEN-1`: `o_group_cnt` goes to 0 and `o_piece` increments.
  - When `o_piece==out_piece-1` at that same point: `o_piece` goes to 0 and the state goes to GROUP_END.
- **GROUP_END** (one cycle)
  - `o_group_end=1` and `in_cnt` increments.
  - If `in_cnt==in_piece-1` go to DONE, otherwise go to WAIT_FEAT.
- **DONE** (one cycle): `o_fc_out=1`, then go to IDLE.
- Address arithmetic:
  - The address runs linearly and continues across pieces and groups; it is never reset between groups.
  - Wraps modulo 4096 (0xFFF→0x000).
  - Total reads = `in_piece`×`out_piece`×`GROUP_LEN`.
- Ignored inputs:
  - `start_calculate` outside IDLE.
  - `feature_load_end` outside WAIT_FEAT; it is not queued.
  - `mode`, `in_piece`, `out_piece` and `addr_start_w` after the start is latched.

## Timing
- All state and counters are registered.
- `o_rd_en`, `o_w_addr`, `o_group_end` and `o_fc_out` are decoded from the registered state (Moore outputs).
- `o_r_WorkState_next` is combinational and equals IDLE while `rst` is high.
- Start latency:
  - Cycle k: `start_calculate` sampled, so the state is WAIT_FEAT from k+1.
  - Cycle j: `feature_load_end` sampled in WAIT_FEAT, so the first read (`o_rd_en=1`, base address) is in cycle j+1.
- Reads are back-to-back, with no bubbles between pieces.
- `o_group_end` is in the cycle right after the group's last read.
- `o_fc_out` is in the cycle after the final `o_group_end`.
- Reset values:
  - State IDLE.
  - `o_w_addr`, `o_rd_en`, `o_group_end`, `o_fc_out`, `o_piece` and `o_group_cnt` are 0.
  - `o_r_WorkState` is 0.
- Reset mid-operation:
  - The next edge returns the block to IDLE with all counters cleared.
  - No `o_group_end` or `o_fc_out` pulse is generated.

## Structure
- Shared package `wagu_pkg`: the state encoding constants (4-bit) and `MODE_FC`.
- Single flat module with no sub-modules: one state register, the next-state logic, and the `addr_cnt`, `in_cnt`, piece and word counters.

## Test plan
- **Single group, two pieces**
  - Stimulus: `GROUP_LEN=16`, `in_piece=1`, `out_piece=2`, base 0x000; start, then `feature_load_end` two cycles later.
  - Required: 32 consecutive reads at 0x000..0x01F; `o_piece` goes 0→1 after address 0x00F; then one `o_group_end`, then one `o_fc_out`, then IDLE.
- **Multiple groups**
  - Stimulus: `in_piece=3`, `out_piece=1`, base 0x100, with a `feature_load_end` pulse for each group.
  - Required: reads at 0x100..0x10F, 0x110..0x11F and 0x120..0x12F; `o_group_end` three times; WAIT_FEAT holds with `o_rd_en=0` until each pulse; exactly one `o_fc_out`.
- **Address wrap**
  - Stimulus: base 0xFF8, `in_piece=1`, `out_piece=1`.
  - Required: addresses 0xFF8..0xFFF, then 0x000..0x007.
- **Rejected starts**
  - Stimulus: `mode=4'd1`, or `in_piece=0`, each with a start pulse.
  - Required: state stays IDLE and `o_rd_en` never rises.
- **Spurious and held inputs**
  - Stimulus: `feature_load_end` during READ, and a second `start_calculate` during WAIT_FEAT.
  - Required: both are ignored and the read sequence is unchanged.
- **Reset mid-operation**
  - Stimulus: assert `rst` during READ, at `o_group_cnt=5`.
  - Required: the next cycle shows IDLE with all outputs 0 and no `o_fc_out`; a fresh start then reads from the new base.
